// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core
//   RC4 stream decryptor driving three external synchronous memories. A run
//   builds the 256-byte state table S (INIT), mixes in the key (KSA), then
//   generates one keystream byte per message byte (PRGA). Each keystream byte
//   is XORed with the encrypted ROM byte and written to the decrypted RAM.
//
//   Every external memory has a 1-cycle registered read: an address launched
//   at edge N is sampled by the memory at edge N+1. Its data is consumed at
//   edge N+2. Each read therefore has a launch state, a wait state and a
//   capture state.
//
// Parameters
//   KEY_BYTES  key length in bytes (1..32)
//   MSG_LEN    message length in bytes (1..256)
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   begin a run (accepted only while idle)
//   secret_key              key, byte 0 in the most significant position
//   busy, done, valid       run in progress / 1-cycle completion / plausibility
//   s_addr, s_wdata, s_wren, s_rdata   S-table RAM (256 x 8)
//   m_addr, m_rdata                    encrypted message ROM
//   d_addr, d_wdata, d_wren            decrypted message RAM
//
// Build option
//   RC4_VALID_CHECK_EN  when defined, each plaintext byte must be a lowercase
//                       letter or a space. The first failing byte is not
//                       written, and the run ends with valid=0. When the macro
//                       is undefined, every byte is written and valid equals
//                       done.

module rc4_decrypt_core #(
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned MSG_LEN   = 32,
   localparam int unsigned MAW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [KEY_BYTES*8-1:0] secret_key,
   output logic                   busy,
   output logic                   done,
   output logic                   valid,
   output logic [7:0]             s_addr,
   output logic [7:0]             s_wdata,
   output logic                   s_wren,
   input  logic [7:0]             s_rdata,
   output logic [MAW-1:0]         m_addr,
   input  logic [7:0]             m_rdata,
   output logic [MAW-1:0]         d_addr,
   output logic [7:0]             d_wdata,
   output logic                   d_wren
);

   localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KIW-1:0] LastKeyIdx = KIW'(KEY_BYTES - 1);
   localparam logic [MAW-1:0] LastK      = MAW'(MSG_LEN - 1);

   typedef enum logic [4:0] {
      StIdle,
      StInit,
      StKsaRdI,
      StKsaWaitI,
      StKsaGetI,
      StKsaWaitJ,
      StKsaGetJ,
      StKsaWrJ,
      StPrgaRdI,
      StPrgaWaitI,
      StPrgaGetI,
      StPrgaWaitJ,
      StPrgaGetJ,
      StPrgaWrJ,
      StPrgaRdF,
      StPrgaWaitF,
      StPrgaGetF,
      StDone
   } state_t;

   state_t                 state_q;
   logic [KEY_BYTES*8-1:0] key_q;
   logic [KIW-1:0]         key_idx_q;   // tracks i mod KEY_BYTES without a divider
   logic [7:0]             i_q;
   logic [7:0]             j_q;
   logic [MAW-1:0]         k_q;
   logic [7:0]             si_q;        // S[i] held across the swap
   logic [7:0]             sum_q;       // S[i]+S[j], the keystream lookup index
   logic [7:0]             m_q;         // ciphertext byte for the current k
   logic                   pass_q;      // no plaintext byte has failed the check
   logic                   busy_q;
   logic                   done_q;
   logic                   valid_q;
   logic [7:0]             s_addr_q;
   logic [7:0]             s_wdata_q;
   logic                   s_wren_q;
   logic [MAW-1:0]         m_addr_q;
   logic [MAW-1:0]         d_addr_q;
   logic [7:0]             d_wdata_q;
   logic                   d_wren_q;

   // Key bytes in index order: key_arr[0] is the most significant byte.
   logic [7:0] key_arr [KEY_BYTES];
   for (genvar g = 0; g < KEY_BYTES; g++) begin : g_key
      assign key_arr[g] = key_q[8*(KEY_BYTES-1-g) +: 8];
   end

   logic [7:0] key_byte;
   logic [7:0] i_inc;
   logic [7:0] j_ksa;
   logic [7:0] j_prga;
   logic [7:0] plain;
   logic       plain_ok;

   always_comb begin
      key_byte = key_arr[key_idx_q];
      i_inc    = i_q + 8'd1;
      j_ksa    = j_q + s_rdata + key_byte;
      j_prga   = j_q + s_rdata;
      plain    = s_rdata ^ m_q;
   end

`ifdef RC4_VALID_CHECK_EN
   assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
`else
   assign plain_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         key_q     <= '0;
         key_idx_q <= '0;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         si_q      <= '0;
         sum_q     <= '0;
         m_q       <= '0;
         pass_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_wren_q  <= 1'b0;
         m_addr_q  <= '0;
         d_addr_q  <= '0;
         d_wdata_q <= '0;
         d_wren_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done_q <= 1'b0;
`ifndef RC4_VALID_CHECK_EN
               valid_q <= 1'b0;
`endif
               if (start) begin
                  key_q   <= secret_key;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b0;
                  pass_q  <= 1'b1;
                  i_q     <= '0;
                  state_q <= StInit;
               end
            end

            // S[i] = i, one write per cycle; i wraps back to 0 for KSA.
            StInit: begin
               s_wren_q  <= 1'b1;
               s_addr_q  <= i_q;
               s_wdata_q <= i_q;
               i_q       <= i_inc;
               if (i_q == 8'd255) begin
                  j_q       <= '0;
                  key_idx_q <= '0;
                  state_q   <= StKsaRdI;
               end
            end

            StKsaRdI: begin
               s_wren_q <= 1'b0;
               s_addr_q <= i_q;
               state_q  <= StKsaWaitI;
            end
            StKsaWaitI: state_q <= StKsaGetI;
            StKsaGetI: begin
               si_q      <= s_rdata;
               j_q       <= j_ksa;
               s_addr_q  <= j_ksa;
               key_idx_q <= (key_idx_q == LastKeyIdx) ? '0 : key_idx_q + KIW'(1);
               state_q   <= StKsaWaitJ;
            end
            StKsaWaitJ: state_q <= StKsaGetJ;
            // Swap: S[i] <= S[j] now, S[j] <= old S[i] next cycle. With i==j
            // both writes store the same byte, so S is unchanged.
            StKsaGetJ: begin
               s_wren_q  <= 1'b1;
               s_addr_q  <= i_q;
               s_wdata_q <= s_rdata;
               state_q   <= StKsaWrJ;
            end
            StKsaWrJ: begin
               s_wren_q  <= 1'b1;
               s_addr_q  <= j_q;
               s_wdata_q <= si_q;
               i_q       <= i_inc;
               if (i_q == 8'd255) begin
                  j_q     <= '0;
                  k_q     <= '0;
                  state_q <= StPrgaRdI;
               end else begin
                  state_q <= StKsaRdI;
               end
            end

            // The ciphertext read is launched alongside the S[i] read.
            StPrgaRdI: begin
               s_wren_q <= 1'b0;
               d_wren_q <= 1'b0;
               i_q      <= i_inc;
               s_addr_q <= i_inc;
               m_addr_q <= k_q;
               state_q  <= StPrgaWaitI;
            end
            StPrgaWaitI: state_q <= StPrgaGetI;
            StPrgaGetI: begin
               si_q     <= s_rdata;
               m_q      <= m_rdata;
               j_q      <= j_prga;
               s_addr_q <= j_prga;
               state_q  <= StPrgaWaitJ;
            end
            StPrgaWaitJ: state_q <= StPrgaGetJ;
            StPrgaGetJ: begin
               sum_q     <= si_q + s_rdata;
               s_wren_q  <= 1'b1;
               s_addr_q  <= i_q;
               s_wdata_q <= s_rdata;
               state_q   <= StPrgaWrJ;
            end
            StPrgaWrJ: begin
               s_wren_q  <= 1'b1;
               s_addr_q  <= j_q;
               s_wdata_q <= si_q;
               state_q   <= StPrgaRdF;
            end
            // The swap's last write lands on this edge, before the lookup is
            // sampled, so the lookup reads the post-swap table.
            StPrgaRdF: begin
               s_wren_q <= 1'b0;
               s_addr_q <= sum_q;
               state_q  <= StPrgaWaitF;
            end
            StPrgaWaitF: state_q <= StPrgaGetF;
            StPrgaGetF: begin
               if (!plain_ok) begin
                  pass_q  <= 1'b0;
                  state_q <= StDone;
               end else begin
                  d_wren_q  <= 1'b1;
                  d_addr_q  <= k_q;
                  d_wdata_q <= plain;
                  if (k_q == LastK) begin
                     state_q <= StDone;
                  end else begin
                     k_q     <= k_q + MAW'(1);
                     state_q <= StPrgaRdI;
                  end
               end
            end

            StDone: begin
               d_wren_q <= 1'b0;
               s_wren_q <= 1'b0;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               valid_q  <= pass_q;
               state_q  <= StIdle;
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign valid   = valid_q;
   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_wren  = s_wren_q;
   assign m_addr  = m_addr_q;
   assign d_addr  = d_addr_q;
   assign d_wdata = d_wdata_q;
   assign d_wren  = d_wren_q;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
module tb_rc4_decrypt_core;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Instance "w": KEY_BYTES=4, MSG_LEN=5
   logic        w_start = 1'b0;
   logic [31:0] w_key = '0;
   logic        w_busy, w_done, w_valid;
   logic [7:0]  w_s_addr, w_s_wdata, w_s_rdata;
   logic        w_s_wren;
   logic [2:0]  w_m_addr, w_d_addr;
   logic [7:0]  w_m_rdata, w_d_wdata;
   logic        w_d_wren;

   // Instance "k": KEY_BYTES=3, MSG_LEN=9
   logic        k_start = 1'b0;
   logic [23:0] k_key = '0;
   logic        k_busy, k_done, k_valid;
   logic [7:0]  k_s_addr, k_s_wdata, k_s_rdata;
   logic        k_s_wren;
   logic [3:0]  k_m_addr, k_d_addr;
   logic [7:0]  k_m_rdata, k_d_wdata;
   logic        k_d_wren;

   rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(5)) u_w (
      .clk(clk), .reset_n(reset_n), .start(w_start), .secret_key(w_key),
      .busy(w_busy), .done(w_done), .valid(w_valid),
      .s_addr(w_s_addr), .s_wdata(w_s_wdata), .s_wren(w_s_wren), .s_rdata(w_s_rdata),
      .m_addr(w_m_addr), .m_rdata(w_m_rdata),
      .d_addr(w_d_addr), .d_wdata(w_d_wdata), .d_wren(w_d_wren)
   );

   rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9)) u_k (
      .clk(clk), .reset_n(reset_n), .start(k_start), .secret_key(k_key),
      .busy(k_busy), .done(k_done), .valid(k_valid),
      .s_addr(k_s_addr), .s_wdata(k_s_wdata), .s_wren(k_s_wren), .s_rdata(k_s_rdata),
      .m_addr(k_m_addr), .m_rdata(k_m_rdata),
      .d_addr(k_d_addr), .d_wdata(k_d_wdata), .d_wren(k_d_wren)
   );

   // Synchronous-read memory models
   logic [7:0] w_smem [256];
   logic [7:0] w_rom [8];
   logic [7:0] w_ram [8];
   logic [7:0] k_smem [256];
   logic [7:0] k_rom [16];
   logic [7:0] k_ram [16];

   always @(posedge clk) begin
      if (w_s_wren) w_smem[w_s_addr] <= w_s_wdata;
      w_s_rdata <= w_smem[w_s_addr];
      w_m_rdata <= w_rom[w_m_addr];
      if (w_d_wren) w_ram[w_d_addr] <= w_d_wdata;
      if (k_s_wren) k_smem[k_s_addr] <= k_s_wdata;
      k_s_rdata <= k_smem[k_s_addr];
      k_m_rdata <= k_rom[k_m_addr];
      if (k_d_wren) k_ram[k_d_addr] <= k_d_wdata;
   end

   // Event monitors (never reset; tests work on deltas)
   int w_done_cnt = 0;
   int w_dwr_cnt = 0;
   int k_done_cnt = 0;
   int k_dwr_cnt = 0;
   int both_cnt = 0;
   logic [15:0] k_log [$];

   always @(negedge clk) begin
      if (w_done) w_done_cnt++;
      if (w_d_wren) w_dwr_cnt++;
      if (k_done) k_done_cnt++;
      if (k_d_wren) k_dwr_cnt++;
      if ((w_s_wren && w_d_wren) || (k_s_wren && k_d_wren)) both_cnt++;
      if (k_s_wren) k_log.push_back({k_s_addr, k_s_wdata});
   end

   logic [7:0] ct_w [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
   logic [7:0] pt_w [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
   logic [7:0] ct_k [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
   logic [7:0] pt_k [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

   task automatic load_w();
      for (int i = 0; i < 8; i++) begin
         w_rom[i] = (i < 5) ? ct_w[i] : 8'h00;
         w_ram[i] = 8'h00;
      end
   endtask

   task automatic load_k();
      for (int i = 0; i < 16; i++) begin
         k_rom[i] = (i < 9) ? ct_k[i] : 8'h00;
         k_ram[i] = 8'h00;
      end
   endtask

   task automatic start_w(input logic [31:0] key);
      @(negedge clk);
      w_key = key;
      w_start = 1'b1;
      @(negedge clk);
      w_start = 1'b0;
   endtask

   task automatic start_k(input logic [23:0] key);
      @(negedge clk);
      k_key = key;
      k_start = 1'b1;
      @(negedge clk);
      k_start = 1'b0;
   endtask

   task automatic wait_w(output bit found);
      found = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (w_done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_k(output bit found);
      found = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (k_done) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({w_busy, w_done, w_valid, w_s_wren, w_d_wren} !== 5'b0) begin
         bad++;
         $display("FAIL reset_w_flags: got %b want 00000",
                  {w_busy, w_done, w_valid, w_s_wren, w_d_wren});
      end
      total++;
      if ({w_s_addr, w_m_addr, w_d_addr} !== 14'h0) begin
         bad++;
         $display("FAIL reset_w_addr: got %h want 0", {w_s_addr, w_m_addr, w_d_addr});
      end
      total++;
      if ({k_busy, k_done, k_valid, k_s_wren, k_d_wren} !== 5'b0) begin
         bad++;
         $display("FAIL reset_k_flags: got %b want 00000",
                  {k_busy, k_done, k_valid, k_s_wren, k_d_wren});
      end
      total++;
      if ({k_s_addr, k_m_addr, k_d_addr} !== 16'h0) begin
         bad++;
         $display("FAIL reset_k_addr: got %h want 0", {k_s_addr, k_m_addr, k_d_addr});
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_wiki_pedia();
      bit found;
      int dn0, dw0;
      load_w();
      dn0 = w_done_cnt;
      dw0 = w_dwr_cnt;
      start_w(32'h57696B69);
      total++;
      if (w_busy !== 1'b1) begin
         bad++;
         $display("FAIL wiki_busy_on_start: got %b want 1", w_busy);
      end
      wait_w(found);
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL wiki_done_timeout: got %b want 1", found);
      end
      total++;
      if ({w_valid, w_busy} !== 2'b10) begin
         bad++;
         $display("FAIL wiki_valid_busy_at_done: got %b want 10", {w_valid, w_busy});
      end
      @(negedge clk);
      total++;
      if (w_done !== 1'b0) begin
         bad++;
         $display("FAIL wiki_done_one_cycle: got %b want 0", w_done);
      end
      total++;
      if (w_done_cnt - dn0 != 1) begin
         bad++;
         $display("FAIL wiki_done_pulses: got %0d want 1", w_done_cnt - dn0);
      end
      total++;
      if (w_dwr_cnt - dw0 != 5) begin
         bad++;
         $display("FAIL wiki_d_writes: got %0d want 5", w_dwr_cnt - dw0);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (w_ram[i] !== pt_w[i]) begin
            bad++;
            $display("FAIL wiki_d[%0d]: got %h want %h", i, w_ram[i], pt_w[i]);
         end
      end
   endtask

   task automatic test_key_plaintext();
      bit found;
      int dw0;
      load_k();
      dw0 = k_dwr_cnt;
      start_k(24'h4B6579);
      wait_k(found);
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL key_done_timeout: got %b want 1", found);
      end
`ifdef RC4_VALID_CHECK_EN
      total++;
      if (k_valid !== 1'b0) begin
         bad++;
         $display("FAIL key_valid: got %b want 0", k_valid);
      end
      @(negedge clk);
      total++;
      if (k_dwr_cnt - dw0 != 0) begin
         bad++;
         $display("FAIL key_d_writes: got %0d want 0", k_dwr_cnt - dw0);
      end
      total++;
      if (k_ram[0] !== 8'h00) begin
         bad++;
         $display("FAIL key_d[0]_unwritten: got %h want 00", k_ram[0]);
      end
`else
      total++;
      if (k_valid !== 1'b1) begin
         bad++;
         $display("FAIL key_valid: got %b want 1", k_valid);
      end
      @(negedge clk);
      total++;
      if (k_dwr_cnt - dw0 != 9) begin
         bad++;
         $display("FAIL key_d_writes: got %0d want 9", k_dwr_cnt - dw0);
      end
      for (int i = 0; i < 9; i++) begin
         total++;
         if (k_ram[i] !== pt_k[i]) begin
            bad++;
            $display("FAIL key_d[%0d]: got %h want %h", i, k_ram[i], pt_k[i]);
         end
      end
`endif
   endtask

   task automatic test_ksa_zero_key();
      bit found;
      int base, nbad;
      logic [15:0] e260, e261;
      base = k_log.size();
      start_k(24'h000000);
      wait_k(found);
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL zkey_done_timeout: got %b want 1", found);
      end
      total++;
      if (k_log.size() < base + 262) begin
         bad++;
         $display("FAIL zkey_s_writes: got %0d want >=262", k_log.size() - base);
      end
      nbad = 0;
      for (int i = 0; i < 256; i++) begin
         if (k_log.size() <= base + i) nbad++;
         else if (k_log[base+i] !== {i[7:0], i[7:0]}) nbad++;
      end
      total++;
      if (nbad != 0) begin
         bad++;
         $display("FAIL zkey_init_writes: got %0d wrong want 0", nbad);
      end
      e260 = (k_log.size() > base + 261) ? k_log[base+260] : 16'hxxxx;
      e261 = (k_log.size() > base + 261) ? k_log[base+261] : 16'hxxxx;
      total++;
      if (e260 !== 16'h0203) begin
         bad++;
         $display("FAIL zkey_ksa_i2_first: got %h want 0203", e260);
      end
      total++;
      if (e261 !== 16'h0302) begin
         bad++;
         $display("FAIL zkey_ksa_i2_second: got %h want 0302", e261);
      end
   endtask

   task automatic test_start_ignored();
      bit found;
      int dn0;
      load_w();
      dn0 = w_done_cnt;
      start_w(32'h57696B69);
      repeat (400) @(negedge clk);
      w_key = 32'hDEADBEEF;
      w_start = 1'b1;
      @(negedge clk);
      w_start = 1'b0;
      total++;
      if (w_busy !== 1'b1) begin
         bad++;
         $display("FAIL ign_busy: got %b want 1", w_busy);
      end
      wait_w(found);
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL ign_done_timeout: got %b want 1", found);
      end
      repeat (50) @(negedge clk);
      total++;
      if (w_done_cnt - dn0 != 1) begin
         bad++;
         $display("FAIL ign_done_pulses: got %0d want 1", w_done_cnt - dn0);
      end
      total++;
      if (w_busy !== 1'b0) begin
         bad++;
         $display("FAIL ign_busy_after: got %b want 0", w_busy);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (w_ram[i] !== pt_w[i]) begin
            bad++;
            $display("FAIL ign_d[%0d]: got %h want %h", i, w_ram[i], pt_w[i]);
         end
      end
   endtask

   task automatic test_reset_mid_ksa();
      bit found;
      int dw0;
      load_w();
      start_w(32'h57696B69);
      repeat (600) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({w_busy, w_s_wren, w_d_wren, w_done} !== 4'b0) begin
         bad++;
         $display("FAIL rst_mid_flags: got %b want 0000", {w_busy, w_s_wren, w_d_wren, w_done});
      end
      dw0 = w_dwr_cnt;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if ((w_dwr_cnt - dw0 != 0) || (w_busy !== 1'b0)) begin
         bad++;
         $display("FAIL rst_mid_quiet: got writes=%0d busy=%b want 0 0",
                  w_dwr_cnt - dw0, w_busy);
      end
      load_w();
      start_w(32'h57696B69);
      wait_w(found);
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL rst_rerun_timeout: got %b want 1", found);
      end
      total++;
      if (w_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_rerun_valid: got %b want 1", w_valid);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (w_ram[i] !== pt_w[i]) begin
            bad++;
            $display("FAIL rst_rerun_d[%0d]: got %h want %h", i, w_ram[i], pt_w[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wiki_pedia();
      test_key_plaintext();
      test_ksa_zero_key();
      test_start_ignored();
      test_reset_mid_ksa();
      total++;
      if (both_cnt != 0) begin
         bad++;
         $display("FAIL s_and_d_wren_overlap: got %0d want 0", both_cnt);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
